// File: rtl/bcd_lap_timer_pkg.sv
// Shared constants and types for the BCD lap timer: digit limits, lap FSM encodings, time payload.
package bcd_lap_timer_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned TENTHS_MAX = 9;
    localparam int unsigned SU_MAX     = 9;
    localparam int unsigned ST_MAX     = 5;

    localparam logic [0:0] LIVE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    typedef struct packed {
        logic [DIGIT_W-1:0] m;
        logic [DIGIT_W-1:0] st;
        logic [DIGIT_W-1:0] su;
        logic [DIGIT_W-1:0] t;
    } bcd_time_t;

endpackage

// File: rtl/bcd_lap_timer_digit_counter.sv
// Single BCD digit counter: rolls to 0 after MAX, and any out-of-range value also returns to 0.
module bcd_digit_counter
    import bcd_lap_timer_pkg::*;
#(
    parameter int unsigned MAX = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    output logic [DIGIT_W-1:0] q,
    output logic               co
);

    // Out-of-range values clamp to 0; carry only leaves from exactly MAX.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q >= DIGIT_W'(MAX)) ? '0 : q + DIGIT_W'(1);
        end
    end

    assign co = en && (q == DIGIT_W'(MAX));

endmodule

// File: rtl/bcd_lap_timer.sv
// Tenths-resolution BCD elapsed timer (0:00.0..MAX_MIN:59.9) with lap hold of the displayed value.
module bcd_lap_timer
    import bcd_lap_timer_pkg::*;
#(
    parameter int unsigned MAX_MIN = 9,
    parameter bit          WRAP    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 clr,
    input  logic                 lap,
    output logic [DIGIT_W-1:0]   q0,
    output logic [2*DIGIT_W-1:0] qs,
    output logic [DIGIT_W-1:0]   qm,
    output logic                 held,
    output logic                 ovf
);

    bcd_time_t  live;
    logic       co_t, co_su, co_st, co_m;
    logic       en_su, en_st, en_m;
    logic       terminal_c;
    logic       sat_c;
    logic       adv_c;
    logic [0:0] state_q, state_n;

    assign terminal_c = (live.t  == DIGIT_W'(TENTHS_MAX)) && (live.su == DIGIT_W'(SU_MAX)) &&
                        (live.st == DIGIT_W'(ST_MAX))     && (live.m  == DIGIT_W'(MAX_MIN));

    // In saturate mode the terminal count freezes every digit.
    assign sat_c = terminal_c && !WRAP;
    assign adv_c = tick && !sat_c;

    // Higher digits step on carry, or on any tick when they hold an illegal value.
    assign en_su = co_t  || (adv_c && (live.su > DIGIT_W'(SU_MAX)));
    assign en_st = co_su || (adv_c && (live.st > DIGIT_W'(ST_MAX)));
    assign en_m  = co_st || (adv_c && (live.m  > DIGIT_W'(MAX_MIN)));

    bcd_digit_counter #(.MAX(TENTHS_MAX)) u_t (
        .clk(clk), .reset(reset), .clr(clr), .en(adv_c), .q(live.t), .co(co_t)
    );

    bcd_digit_counter #(.MAX(SU_MAX)) u_su (
        .clk(clk), .reset(reset), .clr(clr), .en(en_su), .q(live.su), .co(co_su)
    );

    bcd_digit_counter #(.MAX(ST_MAX)) u_st (
        .clk(clk), .reset(reset), .clr(clr), .en(en_st), .q(live.st), .co(co_st)
    );

    bcd_digit_counter #(.MAX(MAX_MIN)) u_m (
        .clk(clk), .reset(reset), .clr(clr), .en(en_m), .q(live.m), .co(co_m)
    );

    // Sticky overflow: carry out of the minutes digit when wrapping, or a tick at saturation.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            ovf <= 1'b0;
        end else if (co_m || (tick && sat_c)) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LIVE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        if (clr) begin
            state_n = LIVE;
        end else if (lap) begin
            state_n = (state_q == LIVE) ? HOLD : LIVE;
        end
    end

    assign held = (state_q == HOLD);

    // Display copies the live value while tracking, so it trails live by one clock.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q0 <= '0;
            qs <= '0;
            qm <= '0;
        end else if (state_q == LIVE) begin
            q0 <= live.t;
            qs <= {live.st, live.su};
            qm <= live.m;
        end
    end

endmodule

// File: tb/tb_bcd_lap_timer.sv
// Scoreboard bench for bcd_lap_timer: default, saturating (WRAP=0) and MAX_MIN=5 builds on shared stimulus.
module tb_bcd_lap_timer;

    logic clk = 1'b0;
    logic reset, tick, clr, lap;

    logic [3:0] a_q0, s_q0, f_q0;
    logic [7:0] a_qs, s_qs, f_qs;
    logic [3:0] a_qm, s_qm, f_qm;
    logic       a_held, s_held, f_held;
    logic       a_ovf, s_ovf, f_ovf;

    always #5 clk = ~clk;

    bcd_lap_timer u_dut (
        .clk(clk), .reset(reset), .tick(tick), .clr(clr), .lap(lap),
        .q0(a_q0), .qs(a_qs), .qm(a_qm), .held(a_held), .ovf(a_ovf)
    );

    bcd_lap_timer #(.MAX_MIN(9), .WRAP(1'b0)) u_sat (
        .clk(clk), .reset(reset), .tick(tick), .clr(clr), .lap(lap),
        .q0(s_q0), .qs(s_qs), .qm(s_qm), .held(s_held), .ovf(s_ovf)
    );

    bcd_lap_timer #(.MAX_MIN(5), .WRAP(1'b1)) u_m5 (
        .clk(clk), .reset(reset), .tick(tick), .clr(clr), .lap(lap),
        .q0(f_q0), .qs(f_qs), .qm(f_qm), .held(f_held), .ovf(f_ovf)
    );

    typedef struct {
        int          cyc;
        int          dut;
        logic [17:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [17:0] pick(input int d);
        case (d)
            1:       return {s_q0, s_qs, s_qm, s_held, s_ovf};
            2:       return {f_q0, f_qs, f_qm, f_held, f_ovf};
            default: return {a_q0, a_qs, a_qm, a_held, a_ovf};
        endcase
    endfunction

    // Monitor: pops every expectation due in the current cycle and compares mid-cycle.
    exp_t        mon_e;
    logic [17:0] mon_act;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e   = sb.pop_front();
            mon_act = pick(mon_e.dut);
            n_cmp++;
            if (mon_e.cyc != cyc || mon_act !== mon_e.exp) begin
                n_bad++;
                $display("FAIL %s dut%0d cyc%0d: got q0=%h qs=%h qm=%h held=%b ovf=%b, want q0=%h qs=%h qm=%h held=%b ovf=%b",
                         mon_e.name, mon_e.dut, cyc,
                         mon_act[17:14], mon_act[13:6], mon_act[5:2], mon_act[1], mon_act[0],
                         mon_e.exp[17:14], mon_e.exp[13:6], mon_e.exp[5:2], mon_e.exp[1], mon_e.exp[0]);
            end
        end
    end

    task automatic drive(input logic tk, input logic cl, input logic lp);
        tick = tk;
        clr  = cl;
        lap  = lp;
        @(posedge clk);
        #1;
        tick = 1'b0;
        clr  = 1'b0;
        lap  = 1'b0;
    endtask

    task automatic expect_disp(input string name, input int dut, input logic [3:0] e_q0,
                               input logic [7:0] e_qs, input logic [3:0] e_qm,
                               input logic e_held, input logic e_ovf);
        exp_t e;
        e.cyc  = cyc;
        e.dut  = dut;
        e.exp  = {e_q0, e_qs, e_qm, e_held, e_ovf};
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic ticks(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        clr   = 1'b0;
        lap   = 1'b0;
        drive(0, 0, 0);
        drive(0, 0, 0);
        for (int d = 0; d < 3; d++) expect_disp("por_reset", d, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;

        // Count up across the first minute boundary; display trails by one clock.
        ticks(599);
        expect_disp("lag_599", 0, 4'h8, 8'h59, 4'h0, 1'b0, 1'b0);
        drive(0, 0, 0);
        expect_disp("t599", 0, 4'h9, 8'h59, 4'h0, 1'b0, 1'b0);
        ticks(1);
        expect_disp("lag_600", 0, 4'h9, 8'h59, 4'h0, 1'b0, 1'b0);
        drive(0, 0, 0);
        for (int d = 0; d < 3; d++) expect_disp("t600", d, 4'h0, 8'h00, 4'h1, 1'b0, 1'b0);

        // Lap coinciding with a tick captures the pre-increment value.
        drive(0, 1, 0);
        expect_disp("clr_a", 0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);
        ticks(123);
        drive(1, 0, 1);
        expect_disp("lap_capture", 0, 4'h3, 8'h12, 4'h0, 1'b1, 1'b0);
        ticks(50);
        expect_disp("hold_frozen", 0, 4'h3, 8'h12, 4'h0, 1'b1, 1'b0);
        drive(0, 0, 1);
        expect_disp("lap_release", 0, 4'h3, 8'h12, 4'h0, 1'b0, 1'b0);
        drive(0, 0, 0);
        expect_disp("resume_live", 0, 4'h4, 8'h17, 4'h0, 1'b0, 1'b0);

        // clr beats lap and tick while held.
        drive(0, 1, 0);
        ticks(50);
        drive(0, 0, 1);
        expect_disp("hold_050", 0, 4'h0, 8'h05, 4'h0, 1'b1, 1'b0);
        drive(1, 1, 1);
        expect_disp("clr_tick_lap", 0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);
        drive(0, 0, 0);
        expect_disp("tick_dropped", 0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);

        // Reset mid-count at 3:27.4.
        ticks(2074);
        drive(0, 0, 0);
        expect_disp("at_3274", 0, 4'h4, 8'h27, 4'h3, 1'b0, 1'b0);
        reset = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);
        for (int d = 0; d < 3; d++) expect_disp("mid_reset", d, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(0, 0, 0);
        expect_disp("post_reset", 0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);

        // MAX_MIN=5 build wraps at 5:59.9.
        ticks(3599);
        drive(0, 0, 0);
        expect_disp("m5_term", 2, 4'h9, 8'h59, 4'h5, 1'b0, 1'b0);
        expect_disp("a_559", 0, 4'h9, 8'h59, 4'h5, 1'b0, 1'b0);
        ticks(1);
        expect_disp("m5_ovf_set", 2, 4'h9, 8'h59, 4'h5, 1'b0, 1'b1);
        drive(0, 0, 0);
        expect_disp("m5_wrap", 2, 4'h0, 8'h00, 4'h0, 1'b0, 1'b1);
        expect_disp("a_600", 0, 4'h0, 8'h00, 4'h6, 1'b0, 1'b0);

        // Full-range terminal count: wrap vs saturate.
        ticks(2399);
        drive(0, 0, 0);
        expect_disp("a_term", 0, 4'h9, 8'h59, 4'h9, 1'b0, 1'b0);
        expect_disp("s_term", 1, 4'h9, 8'h59, 4'h9, 1'b0, 1'b0);
        ticks(1);
        drive(0, 0, 0);
        expect_disp("a_wrap", 0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b1);
        expect_disp("s_sat", 1, 4'h9, 8'h59, 4'h9, 1'b0, 1'b1);
        ticks(3);
        drive(0, 0, 0);
        expect_disp("a_ovf_sticky", 0, 4'h3, 8'h00, 4'h0, 1'b0, 1'b1);
        expect_disp("s_ovf_sticky", 1, 4'h9, 8'h59, 4'h9, 1'b0, 1'b1);
        expect_disp("m5_ovf_sticky", 2, 4'h3, 8'h00, 4'h4, 1'b0, 1'b1);
        drive(0, 1, 0);
        for (int d = 0; d < 3; d++) expect_disp("clr_ovf", d, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);
        drive(0, 0, 0);
        expect_disp("after_clr", 0, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);

        repeat (3) drive(0, 0, 0);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout at cyc %0d, want completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
